// File: rtl/prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
// prefix_adder_pipe : 3-stage pipelined group Kogge-Stone adder/subtractor
// rev 1.0
// ============================================================================
module prefix_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int GROUPSIZE = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG    = WIDTH / GROUPSIZE;
  localparam int LOGNG = $clog2(NG);

  // --------------------------------------------------------------------------
  // Handshake and valid bits
  // --------------------------------------------------------------------------
  logic v1_q, v2_q, v3_q;
  logic load1, load2, load3;

  // A stage may load when empty or when its occupant leaves this cycle.
  assign load3    = !v3_q || out_ready;
  assign load2    = !v2_q || load3;
  assign load1    = !v1_q || load2;
  assign in_ready = load1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (load1) v1_q <= in_valid;
      if (load2) v2_q <= v1_q;
      if (load3) v3_q <= v2_q;
    end
  end

  // --------------------------------------------------------------------------
  // S1: operand conditioning, bit p/g and group G/P
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             c0_d;
  logic [WIDTH-1:0] p1_d, g1_d;
  logic [NG-1:0]    gg1_d, gp1_d;

  assign b_eff = in_sub ? ~in_b : in_b;
  assign c0_d  = in_sub ^ in_cin;
  assign p1_d  = in_a ^ b_eff;
  assign g1_d  = in_a & b_eff;

  always_comb begin
    logic g_acc;
    logic p_acc;
    gg1_d = '0;
    gp1_d = '0;
    g_acc = 1'b0;
    p_acc = 1'b1;
    for (int gi = 0; gi < NG; gi++) begin
      g_acc = 1'b0;
      p_acc = 1'b1;
      for (int bi = 0; bi < GROUPSIZE; bi++) begin
        g_acc = g1_d[gi*GROUPSIZE+bi] | (p1_d[gi*GROUPSIZE+bi] & g_acc);
        p_acc = p_acc & p1_d[gi*GROUPSIZE+bi];
      end
      gg1_d[gi] = g_acc;
      gp1_d[gi] = p_acc;
    end
  end

  logic [WIDTH-1:0] p1_q, g1_q;
  logic [NG-1:0]    gg1_q, gp1_q;
  logic             c01_q, amsb1_q, bmsb1_q;
  logic [TAG_W-1:0] tag1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q    <= '0;
      g1_q    <= '0;
      gg1_q   <= '0;
      gp1_q   <= '0;
      c01_q   <= 1'b0;
      amsb1_q <= 1'b0;
      bmsb1_q <= 1'b0;
      tag1_q  <= '0;
    end else if (load1 && in_valid) begin
      p1_q    <= p1_d;
      g1_q    <= g1_d;
      gg1_q   <= gg1_d;
      gp1_q   <= gp1_d;
      c01_q   <= c0_d;
      amsb1_q <= in_a[WIDTH-1];
      bmsb1_q <= b_eff[WIDTH-1];
      tag1_q  <= in_tag;
    end
  end

  // --------------------------------------------------------------------------
  // S2: Kogge-Stone prefix over groups
  // --------------------------------------------------------------------------
  logic [NG-1:0] kg [0:LOGNG];
  logic [NG-1:0] kp [0:LOGNG-1];
  logic [NG:0]   gc_d;

  always_comb begin
    for (int l = 0; l <= LOGNG; l++) kg[l] = '0;
    for (int l = 0; l < LOGNG; l++)  kp[l] = '0;
    // Carry-in is absorbed into group 0 so every prefix G is a true carry.
    kg[0]    = gg1_q;
    kg[0][0] = gg1_q[0] | (gp1_q[0] & c01_q);
    kp[0]    = gp1_q;
    kp[0][0] = 1'b0;
    for (int l = 0; l < LOGNG; l++) begin
      for (int i = 0; i < NG; i++) begin
        if (i >= (1 << l)) begin
          kg[l+1][i] = kg[l][i] | (kp[l][i] & kg[l][i-(1<<l)]);
          if (l + 1 < LOGNG) kp[l+1][i] = kp[l][i] & kp[l][i-(1<<l)];
        end else begin
          kg[l+1][i] = kg[l][i];
          if (l + 1 < LOGNG) kp[l+1][i] = kp[l][i];
        end
      end
    end
    gc_d[0] = c01_q;
    for (int i = 0; i < NG; i++) gc_d[i+1] = kg[LOGNG][i];
  end

  logic [WIDTH-1:0] p2_q, g2_q;
  logic [NG:0]      gc2_q;
  logic             amsb2_q, bmsb2_q;
  logic [TAG_W-1:0] tag2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_q    <= '0;
      g2_q    <= '0;
      gc2_q   <= '0;
      amsb2_q <= 1'b0;
      bmsb2_q <= 1'b0;
      tag2_q  <= '0;
    end else if (load2 && v1_q) begin
      p2_q    <= p1_q;
      g2_q    <= g1_q;
      gc2_q   <= gc_d;
      amsb2_q <= amsb1_q;
      bmsb2_q <= bmsb1_q;
      tag2_q  <= tag1_q;
    end
  end

  // --------------------------------------------------------------------------
  // S3: in-group ripple, sum and flags
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] carry3;
  logic [WIDTH-1:0] sum3_d;
  logic             cout3_d, ovf3_d, zero3_d;

  always_comb begin
    logic c;
    carry3 = '0;
    c      = 1'b0;
    for (int gi = 0; gi < NG; gi++) begin
      c = gc2_q[gi];
      for (int bi = 0; bi < GROUPSIZE; bi++) begin
        carry3[gi*GROUPSIZE+bi] = c;
        c = g2_q[gi*GROUPSIZE+bi] | (p2_q[gi*GROUPSIZE+bi] & c);
      end
    end
  end

  assign sum3_d  = p2_q ^ carry3;
  assign cout3_d = gc2_q[NG];
  assign ovf3_d  = (amsb2_q == bmsb2_q) && (sum3_d[WIDTH-1] != amsb2_q);
  assign zero3_d = ~|sum3_d;

  logic [WIDTH-1:0] sum3_q;
  logic             cout3_q, ovf3_q, zero3_q;
  logic [TAG_W-1:0] tag3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum3_q  <= '0;
      cout3_q <= 1'b0;
      ovf3_q  <= 1'b0;
      zero3_q <= 1'b0;
      tag3_q  <= '0;
    end else if (load3 && v2_q) begin
      sum3_q  <= sum3_d;
      cout3_q <= cout3_d;
      ovf3_q  <= ovf3_d;
      zero3_q <= zero3_d;
      tag3_q  <= tag2_q;
    end
  end

  assign out_valid = v3_q;
  assign out_sum   = sum3_q;
  assign out_cout  = cout3_q;
  assign out_ovf   = ovf3_q;
  assign out_zero  = zero3_q;
  assign out_tag   = tag3_q;

endmodule
`default_nettype wire

// File: tb/tb_prefix_adder_pipe.sv
`default_nettype none
// ============================================================================
// tb_prefix_adder_pipe : scoreboard bench for the pipelined prefix adder
// rev 1.0
// ============================================================================
module tb_prefix_adder_pipe;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  localparam int N_OPS  = 10000;
  localparam int BUDGET = 40000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush, in_valid, in_ready, in_cin, in_sub;
  logic [31:0] in_a, in_b, out_sum;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;

  logic        w64_in_valid, w64_in_ready, w64_in_cin, w64_in_sub;
  logic [63:0] w64_in_a, w64_in_b, w64_out_sum;
  logic [3:0]  w64_in_tag, w64_out_tag;
  logic        w64_out_valid, w64_out_ready, w64_out_cout, w64_out_ovf, w64_out_zero;

  logic        w16_in_valid, w16_in_ready, w16_in_cin, w16_in_sub;
  logic [15:0] w16_in_a, w16_in_b, w16_out_sum;
  logic [3:0]  w16_in_tag, w16_out_tag;
  logic        w16_out_valid, w16_out_ready, w16_out_cout, w16_out_ovf, w16_out_zero;

  prefix_adder_pipe #(.WIDTH(32), .GROUPSIZE(4), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag)
  );

  prefix_adder_pipe #(.WIDTH(64), .GROUPSIZE(8), .TAG_W(4)) u_w64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(w64_in_valid), .in_ready(w64_in_ready), .in_a(w64_in_a), .in_b(w64_in_b),
    .in_cin(w64_in_cin), .in_sub(w64_in_sub), .in_tag(w64_in_tag),
    .out_valid(w64_out_valid), .out_ready(w64_out_ready), .out_sum(w64_out_sum),
    .out_cout(w64_out_cout), .out_ovf(w64_out_ovf), .out_zero(w64_out_zero), .out_tag(w64_out_tag)
  );

  prefix_adder_pipe #(.WIDTH(16), .GROUPSIZE(2), .TAG_W(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(w16_in_valid), .in_ready(w16_in_ready), .in_a(w16_in_a), .in_b(w16_in_b),
    .in_cin(w16_in_cin), .in_sub(w16_in_sub), .in_tag(w16_in_tag),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready), .out_sum(w16_out_sum),
    .out_cout(w16_out_cout), .out_ovf(w16_out_ovf), .out_zero(w16_out_zero), .out_tag(w16_out_tag)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t q16[$];

  // Arithmetic reference: a +/- b +/- cin evaluated in wide unsigned and signed integers.
  function automatic exp_t golden(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub, input logic [3:0] tag);
    exp_t r;
    logic [65:0] mask, ua, ub, uc, full;
    logic signed [65:0] sa, sb, sc, res, smax, smin;
    mask = (66'd1 << w) - 66'd1;
    ua   = {2'b00, a} & mask;
    ub   = {2'b00, b} & mask;
    uc   = {65'd0, cin};
    full = sub ? (ua - ub - uc) : (ua + ub + uc);
    r.sum  = 64'(full & mask);
    r.cout = sub ? (ua >= ub + uc) : full[w];
    sa   = ua[w-1] ? $signed(ua - (66'd1 << w)) : $signed(ua);
    sb   = ub[w-1] ? $signed(ub - (66'd1 << w)) : $signed(ub);
    sc   = $signed(uc);
    res  = sub ? (sa - sb - sc) : (sa + sb + sc);
    smax = $signed((66'd1 << (w - 1)) - 66'd1);
    smin = -$signed(66'd1 << (w - 1));
    r.ovf  = (res > smax) || (res < smin);
    r.zero = (r.sum == 64'd0);
    r.tag  = tag;
    return r;
  endfunction

  function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o,
                              input logic z, input logic [3:0] t);
    exp_t r;
    r.sum = s; r.cout = c; r.ovf = o; r.zero = z; r.tag = t;
    return r;
  endfunction

  function automatic exp_t cap32();
    return mk({32'd0, out_sum}, out_cout, out_ovf, out_zero, out_tag);
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] r, mask;
    r    = {$urandom, $urandom};
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0: r = '1;
      1: r = '0;
      2: r = 64'd1 << (w - 1);
      3: r = 64'd1;
      default: ;
    endcase
    return r & mask;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic [3:0] tag);
    in_valid = v; in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
  endtask

  task automatic test_reset();
    logic [43:0] outs;
    repeat (2) step();
    n_checks++;
    outs = {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag};
    if (outs !== 44'd0) begin
      n_fail++; $display("FAIL reset_initial: outputs %h, required 0", outs);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: in_ready %b, required 1", in_ready);
    end
    // Fill all three stages with a stalled consumer, then reset mid-flight.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, $urandom | 32'h1, $urandom, 1'b0, 1'b0, 4'(k + 8));
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_prefill: out_valid %b, required 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    outs = {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag};
    if (outs !== 44'd0) begin
      n_fail++; $display("FAIL reset_async_clear: outputs %h, required 0", outs);
    end
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: in_ready %b, required 1", in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_pulse: out_valid %b at cycle %0d, required 0", out_valid, k);
      end
    end
    q32.delete();
  endtask

  task automatic test_add_carry();
    exp_t e, got;
    out_ready = 1'b1;
    q32.push_back(mk(64'h0, 1'b1, 1'b0, 1'b1, 4'd5));
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd5);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_in_ready: in_ready %b, required 1", in_ready);
    end
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL add_early_valid: out_valid %b at stage %0d, required 0", out_valid, k + 1);
      end
      step();
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL add_latency: out_valid %b, required 1", out_valid);
    end
    e = q32.pop_front();
    got = cap32();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL add_carry_result: got %h, required %h", got, e);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_single_pulse: out_valid %b, required 0", out_valid);
    end
  endtask

  task automatic test_sub_ovf();
    exp_t e, got;
    out_ready = 1'b1;
    q32.push_back(mk(64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 4'd6));
    drive(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'd6);
    step();
    q32.push_back(mk(64'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'd7));
    drive(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'd7);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 8 && q32.size() > 0; c++) begin
      if (out_valid === 1'b1) begin
        e = q32.pop_front();
        got = cap32();
        n_checks++;
        if (got !== e) begin
          n_fail++; $display("FAIL sub_result: got %h, required %h", got, e);
        end
      end
      step();
    end
    n_checks++;
    if (q32.size() != 0) begin
      n_fail++; $display("FAIL sub_drain: %0d results outstanding, required 0", q32.size());
      q32.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    logic [31:0] a, b, held;
    logic cin, sub;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      q32.push_back(golden(32, {32'd0, a}, {32'd0, b}, cin, sub, 4'(k + 1)));
      drive(1'b1, a, b, cin, sub, 4'(k + 1));
      step();
    end
    out_ready = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    q32.push_back(golden(32, {32'd0, a}, {32'd0, b}, cin, sub, 4'd4));
    drive(1'b1, a, b, cin, sub, 4'd4);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready_low: in_ready %b, required 0", in_ready);
    end
    n_checks++;
    if ({out_valid, out_tag} !== 5'b1_0001) begin
      n_fail++; $display("FAIL bp_head: valid/tag %b/%0d, required 1/1", out_valid, out_tag);
    end
    held = out_sum;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if ({out_valid, out_tag, out_sum, in_ready} !== {1'b1, 4'd1, held, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold: valid %b tag %0d sum %h ready %b, required 1 1 %h 0",
                 out_valid, out_tag, out_sum, in_ready, held);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: in_ready %b, required 1", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_drain_valid: out_valid %b at slot %0d, required 1", out_valid, k);
      end
      e = q32.pop_front();
      got = cap32();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL bp_drain_data: slot %0d got %h, required %h", k, got, e);
      end
      step();
      if (k == 0) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty: out_valid %b, required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    exp_t e, got;
    logic [31:0] a, b;
    out_ready = 1'b1;
    drive(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 4'd10);
    step();
    drive(1'b1, 32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0, 4'd11);
    step();
    drive(1'b1, 32'h5555_5555, 32'h6666_6666, 1'b0, 1'b1, 4'd12);
    flush = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_in_ready: in_ready %b, required 1", in_ready);
    end
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_no_valid: out_valid %b at cycle %0d, required 0", out_valid, k);
      end
      step();
    end
    a = $urandom; b = $urandom;
    q32.push_back(golden(32, {32'd0, a}, {32'd0, b}, 1'b1, 1'b0, 4'd13));
    drive(1'b1, a, b, 1'b1, 1'b0, 4'd13);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_next_early: out_valid %b at stage %0d, required 0", out_valid, k + 1);
      end
      step();
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_next_latency: out_valid %b, required 1", out_valid);
    end
    e = q32.pop_front();
    got = cap32();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL flush_next_data: got %h, required %h", got, e);
    end
    step();
  endtask

  task automatic test_sweep();
    fork
      begin
        logic [63:0] a, b;
        logic cin, sub, pend;
        logic [3:0] tag;
        int sent, cyc;
        exp_t e, got;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag = '0; pend = 1'b0; sent = 0; cyc = 0;
        while ((sent < N_OPS || q64.size() != 0) && cyc < BUDGET) begin
          if (!pend && sent < N_OPS && $urandom_range(0, 3) != 0) begin
            a = pick(64); b = pick(64);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            tag = 4'($urandom_range(0, 15)); pend = 1'b1;
          end
          w64_in_valid = pend; w64_in_a = a; w64_in_b = b;
          w64_in_cin = cin; w64_in_sub = sub; w64_in_tag = tag;
          w64_out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (w64_out_valid && w64_out_ready) begin
            got = mk(w64_out_sum, w64_out_cout, w64_out_ovf, w64_out_zero, w64_out_tag);
            n_checks++;
            if (q64.size() == 0) begin
              n_fail++; $display("FAIL w64_unexpected: got %h with nothing outstanding", got);
            end else begin
              e = q64.pop_front();
              if (got !== e) begin
                n_fail++; $display("FAIL w64_result: got %h, required %h", got, e);
              end
            end
          end
          if (pend && w64_in_ready) begin
            q64.push_back(golden(64, a, b, cin, sub, tag));
            sent++;
            pend = 1'b0;
          end
          step();
          cyc++;
        end
        w64_in_valid = 1'b0;
        n_checks++;
        if (sent != N_OPS || q64.size() != 0) begin
          n_fail++; $display("FAIL w64_drain: sent %0d outstanding %0d, required %0d and 0", sent, q64.size(), N_OPS);
        end
      end
      begin
        logic [63:0] a, b;
        logic cin, sub, pend;
        logic [3:0] tag;
        int sent, cyc;
        exp_t e, got;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag = '0; pend = 1'b0; sent = 0; cyc = 0;
        while ((sent < N_OPS || q16.size() != 0) && cyc < BUDGET) begin
          if (!pend && sent < N_OPS && $urandom_range(0, 3) != 0) begin
            a = pick(16); b = pick(16);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            tag = 4'($urandom_range(0, 15)); pend = 1'b1;
          end
          w16_in_valid = pend; w16_in_a = a[15:0]; w16_in_b = b[15:0];
          w16_in_cin = cin; w16_in_sub = sub; w16_in_tag = tag;
          w16_out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (w16_out_valid && w16_out_ready) begin
            got = mk({48'd0, w16_out_sum}, w16_out_cout, w16_out_ovf, w16_out_zero, w16_out_tag);
            n_checks++;
            if (q16.size() == 0) begin
              n_fail++; $display("FAIL w16_unexpected: got %h with nothing outstanding", got);
            end else begin
              e = q16.pop_front();
              if (got !== e) begin
                n_fail++; $display("FAIL w16_result: got %h, required %h", got, e);
              end
            end
          end
          if (pend && w16_in_ready) begin
            q16.push_back(golden(16, a, b, cin, sub, tag));
            sent++;
            pend = 1'b0;
          end
          step();
          cyc++;
        end
        w16_in_valid = 1'b0;
        n_checks++;
        if (sent != N_OPS || q16.size() != 0) begin
          n_fail++; $display("FAIL w16_drain: sent %0d outstanding %0d, required %0d and 0", sent, q16.size(), N_OPS);
        end
      end
    join
  endtask

  initial begin
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    w64_in_valid = 1'b0; w64_in_a = '0; w64_in_b = '0; w64_in_cin = 1'b0;
    w64_in_sub = 1'b0; w64_in_tag = '0; w64_out_ready = 1'b0;
    w16_in_valid = 1'b0; w16_in_a = '0; w16_in_b = '0; w16_in_cin = 1'b0;
    w16_in_sub = 1'b0; w16_in_tag = '0; w16_out_ready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_add_carry();
    test_sub_ovf();
    test_back_to_back();
    test_flush();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
